// File: rtl/reset_ctrl_pkg.sv
// rtl/reset_ctrl_pkg.sv - shared state encodings and default timing constants for reset_ctrl
package reset_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_PRESS    = 3'd2,
        ST_CLS      = 3'd3,
        ST_WAIT_REL = 3'd4
    } state_t;

    // Defaults assume the 25 MHz system clock
    localparam int DEF_DEBOUNCE_CYCLES   = 250000;
    localparam int DEF_LONG_PRESS_CYCLES = 25000000;
    localparam int DEF_RESET_HOLD_CYCLES = 256;
    localparam int DEF_CLS_PULSE_CYCLES  = 16;

endpackage

// File: rtl/reset_ctrl_sync_debounce.sv
// rtl/reset_ctrl_sync_debounce.sv - two-flop synchroniser and level debouncer for the reset button
module sync_debounce
    import reset_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk25,
    input  logic rst_n,
    input  logic sig_in,
    output logic sig_out
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Any sample matching the accepted level restarts the stability count
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            cnt     <= '0;
            sig_out <= 1'b1;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            if (sync2 == sig_out) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                sig_out <= sync2;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/reset_ctrl.sv
// rtl/reset_ctrl.sv - button-driven reset / clear-screen controller; RESET_CTRL_CLS_EN enables the short-press clear-screen pulse
module reset_ctrl
    import reset_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int RESET_HOLD_CYCLES = DEF_RESET_HOLD_CYCLES,
    parameter int CLS_PULSE_CYCLES  = DEF_CLS_PULSE_CYCLES
) (
    input  logic clk25,
    input  logic rst_n,
    input  logic btn_n,
    output logic sys_rst_n,
    output logic vga_cls,
    output logic long_press
);

    localparam int                HOLD_W     = $clog2(RESET_HOLD_CYCLES + 1);
    localparam int                PRESS_W    = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [PRESS_W-1:0] PRESS_LAST = PRESS_W'(LONG_PRESS_CYCLES - 1);

    state_t              state;
    state_t              next_state;
    logic                btn_db;
    logic                btn_db_q;
    logic                press_edge;
    logic                released;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [PRESS_W-1:0]  press_cnt;
    logic                sys_rst_n_d;
    logic                long_press_d;

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk25  (clk25),
        .rst_n  (rst_n),
        .sig_in (btn_n),
        .sig_out(btn_db)
    );

    // Only a fresh press in IDLE counts, so a button held through HOLD or CLS is ignored
    assign press_edge = btn_db_q & ~btn_db;
    assign released   = btn_db;

`ifdef RESET_CTRL_CLS_EN
    localparam int               CLS_W    = $clog2(CLS_PULSE_CYCLES + 1);
    localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(CLS_PULSE_CYCLES - 1);

    logic [CLS_W-1:0] cls_cnt;
    logic             vga_cls_d;

    assign vga_cls_d = (next_state == ST_CLS);

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            cls_cnt <= '0;
            vga_cls <= 1'b0;
        end else begin
            cls_cnt <= (state == ST_CLS && next_state == ST_CLS) ? cls_cnt + CLS_W'(1) : '0;
            vga_cls <= vga_cls_d;
        end
    end
`else
    assign vga_cls = 1'b0;
`endif

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HOLD;
            btn_db_q   <= 1'b1;
            hold_cnt   <= '0;
            press_cnt  <= '0;
            sys_rst_n  <= 1'b0;
            long_press <= 1'b0;
        end else begin
            state      <= next_state;
            btn_db_q   <= btn_db;
            hold_cnt   <= (state == ST_HOLD && next_state == ST_HOLD) ? hold_cnt + HOLD_W'(1) : '0;
            press_cnt  <= (state == ST_PRESS && next_state == ST_PRESS) ? press_cnt + PRESS_W'(1) : '0;
            sys_rst_n  <= sys_rst_n_d;
            long_press <= long_press_d;
        end
    end

    // Threshold is tested before release so a tie resolves as a long press
    always_comb begin
        next_state = state;
        case (state)
            ST_HOLD:     if (hold_cnt == HOLD_LAST) next_state = ST_IDLE;
            ST_IDLE:     if (press_edge) next_state = ST_PRESS;
            ST_PRESS: begin
                if (press_cnt == PRESS_LAST) begin
                    next_state = ST_WAIT_REL;
                end else if (released) begin
`ifdef RESET_CTRL_CLS_EN
                    next_state = ST_CLS;
`else
                    next_state = ST_IDLE;
`endif
                end
            end
`ifdef RESET_CTRL_CLS_EN
            ST_CLS:      if (cls_cnt == CLS_LAST) next_state = ST_IDLE;
`endif
            ST_WAIT_REL: if (released) next_state = ST_HOLD;
            default:     next_state = ST_HOLD;
        endcase
    end

    // Outputs are decoded from next_state and registered, giving edge-aligned changes
    always_comb begin
        sys_rst_n_d  = 1'b1;
        long_press_d = 1'b0;
        case (next_state)
            ST_HOLD:     sys_rst_n_d = 1'b0;
            ST_WAIT_REL: begin
                sys_rst_n_d  = 1'b0;
                long_press_d = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reset_ctrl.sv
// tb/tb_reset_ctrl.sv - directed self-checking bench for reset_ctrl
module tb_reset_ctrl;
    import reset_ctrl_pkg::*;

`ifdef RESET_CTRL_CLS_EN
    localparam int CLS_ON = 1;
`else
    localparam int CLS_ON = 0;
`endif

    logic clk25 = 1'b0;
    logic rst_n = 1'b0;
    logic btn_n = 1'b1;
    logic sys_rst_n;
    logic vga_cls;
    logic long_press;

    int n_checks = 0;
    int n_errors = 0;

    int   long_rise, long_cnt, vga_rise, vga_cnt, vga_pulses, sys_rise, sys_low_cnt;
    logic vga_prev, long_prev, sys_prev;

    typedef struct {
        int low;
        int total;
        int long_rise;
        int long_cnt;
        int vga_rise;
        int vga_cnt;
        int vga_pulses;
        int sys_low;
        int sys_rise;
    } vec_t;

    vec_t vecs[4];

    always #20 clk25 = ~clk25;

    reset_ctrl #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(50),
        .RESET_HOLD_CYCLES(8),
        .CLS_PULSE_CYCLES (3)
    ) dut (
        .clk25     (clk25),
        .rst_n     (rst_n),
        .btn_n     (btn_n),
        .sys_rst_n (sys_rst_n),
        .vga_cls   (vga_cls),
        .long_press(long_press)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        long_rise   = 0;
        long_cnt    = 0;
        vga_rise    = 0;
        vga_cnt     = 0;
        vga_pulses  = 0;
        sys_rise    = 0;
        sys_low_cnt = 0;
        vga_prev    = vga_cls;
        long_prev   = long_press;
        sys_prev    = sys_rst_n;
    endtask

    task automatic sample(input int i);
        if (long_press && !long_prev && long_rise == 0) long_rise = i;
        if (long_press) long_cnt++;
        if (vga_cls && !vga_prev) begin
            vga_pulses++;
            if (vga_rise == 0) vga_rise = i;
        end
        if (vga_cls) vga_cnt++;
        if (sys_rst_n && !sys_prev) sys_rise = i;
        if (!sys_rst_n) sys_low_cnt++;
        vga_prev  = vga_cls;
        long_prev = long_press;
        sys_prev  = sys_rst_n;
    endtask

    task automatic run_vec(input int low, input int total);
        clear_stats();
        btn_n = 1'b0;
        for (int i = 1; i <= total; i++) begin
            @(negedge clk25);
            sample(i);
            if (i == low) btn_n = 1'b1;
        end
    endtask

    initial begin
        // {low, total, long_rise, long_cnt, vga_rise, vga_cnt, vga_pulses, sys_low, sys_rise}
        vecs[0] = '{20,  50,  0,  0, 27 * CLS_ON, 3 * CLS_ON, CLS_ON,  0,  0};
        vecs[1] = '{80, 120, 57, 30, 0,           0,          0,      38, 95};
        vecs[2] = '{50,  80, 57,  1, 0,           0,          0,       9, 66};
        vecs[3] = '{49,  70,  0,  0, 56 * CLS_ON, 3 * CLS_ON, CLS_ON,  0,  0};

        repeat (3) @(negedge clk25);
        check("rst_sys_rst_n", int'(sys_rst_n), 0);
        check("rst_vga_cls", int'(vga_cls), 0);
        check("rst_long_press", int'(long_press), 0);
        check("rst_state", int'(dut.state), int'(ST_HOLD));

        clear_stats();
        rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk25);
            sample(i);
        end
        check("por_sys_rise", sys_rise, 8);
        check("por_vga_cnt", vga_cnt, 0);
        check("por_long_cnt", long_cnt, 0);

        for (int k = 0; k < 4; k++) begin
            run_vec(vecs[k].low, vecs[k].total);
            check($sformatf("v%0d_long_rise", k), long_rise, vecs[k].long_rise);
            check($sformatf("v%0d_long_cnt", k), long_cnt, vecs[k].long_cnt);
            check($sformatf("v%0d_vga_rise", k), vga_rise, vecs[k].vga_rise);
            check($sformatf("v%0d_vga_cnt", k), vga_cnt, vecs[k].vga_cnt);
            check($sformatf("v%0d_vga_pulses", k), vga_pulses, vecs[k].vga_pulses);
            check($sformatf("v%0d_sys_low", k), sys_low_cnt, vecs[k].sys_low);
            check($sformatf("v%0d_sys_rise", k), sys_rise, vecs[k].sys_rise);
            check($sformatf("v%0d_end_state", k), int'(dut.state), int'(ST_IDLE));
        end

        clear_stats();
        btn_n = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk25);
            sample(i);
            if (i % 2 == 0 && i < 40) btn_n = ~btn_n;
            if (i == 40) btn_n = 1'b1;
        end
        check("bounce_vga_cnt", vga_cnt, 0);
        check("bounce_sys_low", sys_low_cnt, 0);
        check("bounce_long_cnt", long_cnt, 0);
        check("bounce_state", int'(dut.state), int'(ST_IDLE));

        clear_stats();
        btn_n = 1'b0;
        for (int i = 1; i <= 37; i++) begin
            @(negedge clk25);
            sample(i);
        end
        check("abort_press_cnt", int'(dut.press_cnt), 30);
        check("abort_pre_state", int'(dut.state), int'(ST_PRESS));
        check("abort_pre_sys", int'(sys_rst_n), 1);
        #5;
        rst_n = 1'b0;
        #1;
        check("abort_sys_rst_n", int'(sys_rst_n), 0);
        check("abort_vga_cls", int'(vga_cls), 0);
        check("abort_long_press", int'(long_press), 0);
        check("abort_state", int'(dut.state), int'(ST_HOLD));
        check("abort_cnt_clr", int'(dut.press_cnt), 0);
        btn_n = 1'b1;
        repeat (3) @(negedge clk25);
        clear_stats();
        rst_n = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk25);
            sample(i);
        end
        check("abort_sys_rise", sys_rise, 8);
        check("abort_vga_cnt", vga_cnt, 0);
        check("abort_long_cnt", long_cnt, 0);
        check("abort_end_state", int'(dut.state), int'(ST_IDLE));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reset_ctrl.md
RESET_CTRL -- requirements
Module: reset_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000: consecutive stable samples needed to accept a button level change (10 ms at 25 MHz).
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 25000000: debounced press duration that selects system reset (1 s).
REQ-003 SHALL have parameter RESET_HOLD_CYCLES, default 256: cycles sys_rst_n stays low after a reset cause ends.
REQ-004 SHALL have parameter CLS_PULSE_CYCLES, default 16: vga_cls high width after a short press.
REQ-005 SHALL have port clk25, input, 1 bit: 25 MHz system clock, the only clock.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset, driven from PLL lock.
REQ-007 SHALL have port btn_n, input, 1 bit: raw active-low push button, asynchronous to clk25.
REQ-008 SHALL have port sys_rst_n, output, 1 bit: active-low reset to the apple1 core, synchronous to clk25.
REQ-009 SHALL have port vga_cls, output, 1 bit: active-high clear-screen request to the apple1 core.
REQ-010 SHALL have port long_press, output, 1 bit: high while a long press is held (LED indication).

Function
REQ-011 SHALL synchronise btn_n through two flip-flops before any other use.
REQ-012 SHALL change the debounced level only after DEBOUNCE_CYCLES consecutive synchronised samples differ from it; any sample equal to the current level SHALL restart the count.
REQ-013 SHALL size all counters from the parameters with $clog2, with no truncation at the default values.
REQ-014 SHALL implement FSM states HOLD, IDLE, PRESS, CLS and WAIT_REL.
REQ-015 HOLD: sys_rst_n=0; count to RESET_HOLD_CYCLES; then go to IDLE with sys_rst_n=1 on the next edge; a press during HOLD SHALL be ignored.
REQ-016 IDLE: a debounced press edge SHALL enter PRESS and clear the press counter.
REQ-017 PRESS: a debounced release before the counter reaches LONG_PRESS_CYCLES-1 SHALL enter CLS.
REQ-018 PRESS: reaching LONG_PRESS_CYCLES-1 SHALL enter WAIT_REL, drive sys_rst_n=0 and drive long_press=1 from that edge.
REQ-019 CLS: vga_cls=1 for exactly CLS_PULSE_CYCLES cycles, then return to IDLE; presses during CLS SHALL be ignored until IDLE.
REQ-020 WAIT_REL: sys_rst_n=0 and long_press=1 until debounced release, then enter HOLD.
REQ-021 SHALL register all outputs, so no combinational path exists from btn_n to any output.
REQ-022 A release and the long threshold on the same cycle SHALL resolve as a long press.

Reset
REQ-023 While rst_n=0: sys_rst_n=0, vga_cls=0, long_press=0, state=HOLD, counters=0, debounced level=released, synchronisers=1.
REQ-024 Deassertion of rst_n SHALL start the HOLD count; rst_n asserting mid-operation SHALL abort any state immediately.

Configuration
REQ-025 With RESET_CTRL_CLS_EN defined, short presses SHALL behave per REQ-017 and REQ-019.
REQ-026 Without RESET_CTRL_CLS_EN, the CLS state and its counter SHALL be omitted, a short release SHALL return to IDLE, and vga_cls SHALL be tied to 0.

Structure
REQ-027 FSM state encodings and default cycle constants SHALL live in shared package reset_ctrl_pkg.
REQ-028 The synchroniser plus debounce SHALL be sub-module sync_debounce (ports clk25, rst_n, sig_in, sig_out), instanced once.

Verification
Use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=50, RESET_HOLD_CYCLES=8 and CLS_PULSE_CYCLES=3 unless stated.
REQ-029 Release rst_n with btn_n=1 -> sys_rst_n rises after 8 clk25 cycles (+/-1 for the register stage); vga_cls=0 throughout.
REQ-030 Hold btn_n=0 for 20 cycles, then release -> one vga_cls pulse of exactly 3 cycles; sys_rst_n stays 1.
REQ-031 Toggle btn_n every 2 cycles for 40 cycles -> no state change; vga_cls=0 and sys_rst_n=1.
REQ-032 Hold btn_n=0 for 80 cycles -> sys_rst_n=0 and long_press=1 from the press-count threshold; after release plus debounce plus 8 cycles, sys_rst_n=1 and no vga_cls pulse.
REQ-033 Pull rst_n low during PRESS at count 30 -> all outputs at reset values asynchronously; the subsequent release produces no vga_cls.
REQ-034 Build without RESET_CTRL_CLS_EN and repeat REQ-030 -> vga_cls stays 0 and the FSM returns to IDLE.
